status_reg_stack: RTL and testbench
===================================

Name: status_reg_stack

Overview:
- Parametrised successor to the CPU status register.
- Holds NumStatusBits flags, written either by the ALU or by the decoder, with a per-bit write mask.
- Adds a hardware LIFO of saved status words for call/interrupt context save (push) and restore (pop).
- Adds full/empty indication and sticky overflow/underflow error flags.
- Sits between ALU/decoder and the branch/condition logic; the control unit drives push/pop.

Parameters:
- NumStatusBits, 2, width of the status word (bit0 = carry, bit1 = zero by default).
- StackDepth, 4, number of saved status words (>= 1).
- CntW, $clog2(StackDepth+1), width of the occupancy counter (derived, not overridable).

Ports:
- clk  in  1  system clock, rising-edge active.
- res  in  1  reset, synchronous, active-high.
- wr_en  in  1  enables the status write path this cycle.
- sel_stat_in_alu_decoder  in  1  write source select: 1 = ALU, 0 = decoder.
- alu_status  in  NumStatusBits  flags produced by the ALU.
- dec_status  in  NumStatusBits  flags produced by the decoder.
- wr_mask  in  NumStatusBits  per-bit write enable; bit i = 0 keeps status[i].
- push  in  1  save the current status to the stack.
- pop  in  1  restore status from the stack top.
- clr_err  in  1  clear the sticky error flags.
- status  out  NumStatusBits  registered status word.
- stack_full  out  1  occupancy == StackDepth.
- stack_empty  out  1  occupancy == 0.
- stack_overflow  out  1  sticky: a push was attempted while full.
- stack_underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- All state updates on the rising edge of clk. New values are visible after the edge; status has 1-cycle latency from its inputs.
- Reset (res=1 at an edge):
  - status = 0, occupancy = 0, overflow = underflow = 0.
  - Stack contents are don't-care.
  - stack_empty = 1, stack_full = 0.
  - Reset overrides every other input, including a push/pop in flight.
- Write path:
  - src = sel ? alu_status : dec_status.
  - If wr_en: next = (status & ~wr_mask) | (src & wr_mask); otherwise next = status.
- Decode of push/pop:
  - push=1, pop=0, not full: mem[occ] <= current registered status (pre-edge value); occ += 1; status <= next.
  - push=1, pop=0, full: stack unchanged; overflow <= 1; status <= next.
  - pop=1, push=0, not empty: status <= mem[occ-1]; occ -= 1. The write path is ignored this cycle, so restore wins over wr_en.
  - pop=1, push=0, empty: underflow <= 1; occ stays 0; status <= next.
  - push=1, pop=1: stack and occupancy unchanged; no error flagged; status <= next.
- Error flags:
  - clr_err clears both sticky flags.
  - If an error event occurs in the same cycle as clr_err, the set wins.
- stack_full and stack_empty are combinational from the registered occupancy; no glitches beyond occ.
- occ never wraps: it is held in range 0..StackDepth.

Decomposition:
- Shared package cpu_status_pkg:
  - NUM_STATUS_BITS = 2.
  - Bit indices STAT_C = 0, STAT_Z = 1.
  - Source encoding SEL_DEC = 0, SEL_ALU = 1.
- One natural sub-module, status_lifo:
  - Parametrised storage array plus occupancy counter.
  - Ports: push_ok/pop_ok, din/dout, full/empty.
- The top holds the status register, write mux/mask, error flags and push/pop decode.

Test Plan:
1. Reset: hold res=1 for 2 edges, then release -> status=00, stack_empty=1, stack_full=0, both errors 0.
2. ALU write with mask: wr_en=1, sel=1, alu_status=01, dec_status=11, wr_mask=11 -> status=01 after the edge. Then alu_status=10, wr_mask=01 -> status=00 (bit1 kept, bit0 written 0). Then wr_en=0, alu_status=11 -> status stays 00.
3. Decoder write and push/pop:
   - sel=0, wr_en=1, dec_status=11 -> status=11.
   - push with dec_status=00 in the same cycle -> status=00, occ=1.
   - pop -> status=11, stack_empty=1.
4. Fill and overflow (StackDepth=4): push 4 times with statuses 01,10,11,00 -> stack_full=1. A 5th push -> overflow=1, occupancy stays 4. Pops then return 00,11,10,01 in order.
5. Underflow and clear: pop while empty -> underflow=1, status follows the write path. clr_err together with another empty pop -> underflow remains 1. clr_err alone -> 0.
6. Simultaneous push+pop at occ=2 with wr_en=1, alu_status=10 -> occ stays 2, status=10, no error. Assert res during a push -> occ=0, status=00 after the edge.

Source files
------------

// File: rtl/cpu_status_pkg.sv
// Shared definitions for the CPU status register and its context-save stack.
package cpu_status_pkg;

    // Default width of the status word and the meaning of each flag bit
    localparam int NUM_STATUS_BITS = 2;
    localparam int STAT_C          = 0;
    localparam int STAT_Z          = 1;

    // Encoding of sel_stat_in_alu_decoder
    localparam logic SEL_DEC = 1'b0;
    localparam logic SEL_ALU = 1'b1;

endpackage

// File: rtl/status_lifo.sv
// Storage array plus occupancy counter for saved status words.
// The caller guarantees push_ok is only raised when not full and pop_ok only
// when not empty, and never both at once.
module status_lifo
    import cpu_status_pkg::*;
#(
    parameter int Width = NUM_STATUS_BITS,
    parameter int Depth = 4,
    localparam int CntW = $clog2(Depth + 1),
    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push_ok,
    input  logic             pop_ok,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem [Depth];
    logic [CntW-1:0]  occ;
    logic [CntW-1:0]  occ_m1;
    logic [IdxW-1:0]  wr_idx;
    logic [IdxW-1:0]  rd_idx;

    // The next free slot is occ, the top of stack is occ-1; both stay in range
    // whenever the corresponding push_ok/pop_ok is legal.
    assign occ_m1 = occ - CntW'(1);
    assign wr_idx = occ[IdxW-1:0];
    assign rd_idx = occ_m1[IdxW-1:0];

    assign dout  = mem[rd_idx];
    assign full  = (occ == CntW'(Depth));
    assign empty = (occ == '0);

    // Occupancy counter: only moves on a legal push or pop, so it never wraps
    always_ff @(posedge clk) begin
        if (res) begin
            occ <= '0;
        end else if (push_ok) begin
            occ <= occ + CntW'(1);
        end else if (pop_ok) begin
            occ <= occ_m1;
        end
    end

    // Saved words are data only; their contents after reset are don't-care
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/status_reg_stack.sv
// CPU status register with masked ALU/decoder write path, a LIFO of saved
// status words for call/interrupt context, and sticky stack error flags.
module status_reg_stack
    import cpu_status_pkg::*;
#(
    parameter int NumStatusBits = NUM_STATUS_BITS,
    parameter int StackDepth    = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     wr_en,
    input  logic                     sel_stat_in_alu_decoder,
    input  logic [NumStatusBits-1:0] alu_status,
    input  logic [NumStatusBits-1:0] dec_status,
    input  logic [NumStatusBits-1:0] wr_mask,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic [NumStatusBits-1:0] status,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     stack_overflow,
    output logic                     stack_underflow
);

    // Bits with mask=1 take the new source value, the rest keep their old value
    function automatic logic [NumStatusBits-1:0] merge_masked(
        input logic [NumStatusBits-1:0] old_val,
        input logic [NumStatusBits-1:0] src_val,
        input logic [NumStatusBits-1:0] mask
    );
        return (old_val & ~mask) | (src_val & mask);
    endfunction

    logic [NumStatusBits-1:0] src;
    logic [NumStatusBits-1:0] wr_next;
    logic [NumStatusBits-1:0] lifo_dout;
    logic                     push_req;
    logic                     pop_req;
    logic                     push_ok;
    logic                     pop_ok;

    assign src     = (sel_stat_in_alu_decoder == SEL_ALU) ? alu_status : dec_status;
    assign wr_next = wr_en ? merge_masked(status, src, wr_mask) : status;

    // push together with pop cancels out: no stack movement and no error
    assign push_req = push & ~pop;
    assign pop_req  = pop & ~push;
    assign push_ok  = push_req & ~stack_full;
    assign pop_ok   = pop_req & ~stack_empty;

    status_lifo #(
        .Width (NumStatusBits),
        .Depth (StackDepth)
    ) u_lifo (
        .clk     (clk),
        .res     (res),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .din     (status),
        .dout    (lifo_dout),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    // Status register: a successful restore takes priority over the write path
    always_ff @(posedge clk) begin
        if (res) begin
            status <= '0;
        end else if (pop_ok) begin
            status <= lifo_dout;
        end else begin
            status <= wr_next;
        end
    end

    // Sticky error flags: a new error event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (res) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (push_req && stack_full) begin
                stack_overflow <= 1'b1;
            end else if (clr_err) begin
                stack_overflow <= 1'b0;
            end
            if (pop_req && stack_empty) begin
                stack_underflow <= 1'b1;
            end else if (clr_err) begin
                stack_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed testbench for status_reg_stack: each stimulus cycle queues its
// hand-computed expected outputs; a monitor pops and compares after each edge.
module tb_status_reg_stack;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       wr_en = 1'b0;
    logic       sel = 1'b0;
    logic [1:0] alu_status = '0;
    logic [1:0] dec_status = '0;
    logic [1:0] wr_mask = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [1:0] status;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_overflow;
    logic       stack_underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t exp_q[$];

    status_reg_stack #(
        .NumStatusBits (2),
        .StackDepth    (4)
    ) dut (
        .clk                     (clk),
        .res                     (res),
        .wr_en                   (wr_en),
        .sel_stat_in_alu_decoder (sel),
        .alu_status              (alu_status),
        .dec_status              (dec_status),
        .wr_mask                 (wr_mask),
        .push                    (push),
        .pop                     (pop),
        .clr_err                 (clr_err),
        .status                  (status),
        .stack_full              (stack_full),
        .stack_empty             (stack_empty),
        .stack_overflow          (stack_overflow),
        .stack_underflow         (stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    // Monitor: every edge that has a queued expectation is checked 1ns later
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({e.name, ".status"}, status, e.st);
            check({e.name, ".full"}, {1'b0, stack_full}, {1'b0, e.full});
            check({e.name, ".empty"}, {1'b0, stack_empty}, {1'b0, e.empty});
            check({e.name, ".overflow"}, {1'b0, stack_overflow}, {1'b0, e.ovf});
            check({e.name, ".underflow"}, {1'b0, stack_underflow}, {1'b0, e.udf});
        end
    end

    // Drive one cycle of inputs on the falling edge and queue what must be seen after the next rising edge
    task automatic step(input string n, input logic r, input logic we, input logic sl,
                        input logic [1:0] a, input logic [1:0] d, input logic [1:0] m,
                        input logic ps, input logic pp, input logic ce,
                        input logic [1:0] es, input logic ef, input logic ee,
                        input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        res = r; wr_en = we; sel = sl; alu_status = a; dec_status = d; wr_mask = m;
        push = ps; pop = pp; clr_err = ce;
        e.name = n; e.st = es; e.full = ef; e.empty = ee; e.ovf = eo; e.udf = eu;
        exp_q.push_back(e);
    endtask

    initial begin
        //    name           res we sel alu    dec    mask   psh pop clr  st    full empty ovf udf
        // Reset and release
        step("rst0",         1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        step("rst1",         1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        step("idle",         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        // ALU write with mask
        step("alu_full",     0, 1, 1, 2'b01, 2'b11, 2'b11, 0, 0, 0, 2'b01, 0, 1, 0, 0);
        step("alu_mask01",   0, 1, 1, 2'b10, 2'b11, 2'b01, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        step("wr_off",       0, 0, 1, 2'b11, 2'b11, 2'b11, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        // Decoder write, push with concurrent write, pop restore
        step("dec_wr",       0, 1, 0, 2'b00, 2'b11, 2'b11, 0, 0, 0, 2'b11, 0, 1, 0, 0);
        step("push_wr",      0, 1, 0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step("pop_rest",     0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b11, 0, 1, 0, 0);
        // Fill with 01,10,11,00 then overflow
        step("set01",        0, 1, 0, 2'b00, 2'b01, 2'b11, 0, 0, 0, 2'b01, 0, 1, 0, 0);
        step("fill1",        0, 1, 0, 2'b00, 2'b10, 2'b11, 1, 0, 0, 2'b10, 0, 0, 0, 0);
        step("fill2",        0, 1, 0, 2'b00, 2'b11, 2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 0);
        step("fill3",        0, 1, 0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step("fill4",        0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0, 0);
        step("overflow",     0, 1, 0, 2'b00, 2'b01, 2'b11, 1, 0, 0, 2'b01, 1, 0, 1, 0);
        step("pop4_wins",    0, 1, 0, 2'b00, 2'b11, 2'b11, 0, 1, 0, 2'b00, 0, 0, 1, 0);
        step("pop3",         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b11, 0, 0, 1, 0);
        step("pop2",         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b10, 0, 0, 1, 0);
        step("pop1",         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b01, 0, 1, 1, 0);
        // Clear, underflow, set-wins-over-clear
        step("clr_ovf",      0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 0, 1, 0, 0);
        step("underflow",    0, 1, 1, 2'b10, 2'b00, 2'b11, 0, 1, 0, 2'b10, 0, 1, 0, 1);
        step("udf_clr_set",  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b10, 0, 1, 0, 1);
        step("clr_udf",      0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b10, 0, 1, 0, 0);
        // Simultaneous push+pop at occ=2
        step("set01b",       0, 1, 0, 2'b00, 2'b01, 2'b11, 0, 0, 0, 2'b01, 0, 1, 0, 0);
        step("pushA",        0, 1, 0, 2'b00, 2'b11, 2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 0);
        step("pushB",        0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b11, 0, 0, 0, 0);
        step("push_pop",     0, 1, 1, 2'b10, 2'b00, 2'b11, 1, 1, 0, 2'b10, 0, 0, 0, 0);
        step("popB",         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b11, 0, 0, 0, 0);
        step("popA",         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b01, 0, 1, 0, 0);
        step("pop_empty",    0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b01, 0, 1, 0, 1);
        step("clr2",         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 0, 1, 0, 0);
        // Reset during a push
        step("pushC",        0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 0, 0, 0, 0);
        step("rst_push",     1, 1, 1, 2'b11, 2'b11, 2'b11, 1, 0, 0, 2'b00, 0, 1, 0, 0);
        step("pop_after",    0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 1, 0, 1);
        step("idle_end",     0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 1, 0, 0);

        // Let the monitor drain the queue, bounded by a cycle budget
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
